// File: rtl/peripheral_sync_filter_pkg.sv
// peripheral_sync_pkg: shared constants and counter-width helper for the pin conditioner
// Contents:
//   DEF_STAGES / DEF_FILTER  default synchronizer depth and filter depth
//   cnt_w(filter)            width of a per-bit filter counter, never narrower than 1 bit
package peripheral_sync_pkg;
    localparam int DEF_STAGES = 2;
    localparam int DEF_FILTER = 0;

    // A bypassed filter (0) still gets a 1-bit counter so no zero-width vectors appear.
    function automatic int cnt_w(input int filter);
        return (filter < 1) ? 1 : $clog2(filter + 1);
    endfunction
endpackage

// File: rtl/peripheral_sync_filter_if.sv
// peripheral_sync_filter_if: pad-side inputs and conditioned outputs of the pin conditioner
// Signals:
//   sample_en  filter sample strobe
//   data_in    asynchronous pad levels (WIDTH)
//   data_out   synchronized, filtered levels (WIDTH)
//   rise_out   one-cycle 0->1 pulses (WIDTH)
//   fall_out   one-cycle 1->0 pulses (WIDTH)
// Modports: master drives sample_en/data_in, slave (the conditioner) drives the outputs.
interface peripheral_sync_filter_if #(
    parameter int WIDTH = 1
);
    logic             sample_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] rise_out;
    logic [WIDTH-1:0] fall_out;

    modport master (output sample_en, data_in, input data_out, rise_out, fall_out);
    modport slave  (input sample_en, data_in, output data_out, rise_out, fall_out);
endinterface

// File: rtl/peripheral_sync_filter_bit.sv
// peripheral_sync_filter_bit: one channel of synchronizer, consecutive-sample filter and edge pulses
// Ports:
//   clk, rst_n    receiving clock, asynchronous active-low reset
//   sample_en_i   filter sample strobe (ignored when FILTER == 0)
//   data_i        asynchronous pad level
//   data_o        conditioned level
//   rise_o/fall_o registered one-cycle edge pulses of data_o
module peripheral_sync_filter_bit
    import peripheral_sync_pkg::*;
#(
    parameter int   STAGES    = DEF_STAGES,
    parameter int   FILTER    = DEF_FILTER,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en_i,
    input  logic data_i,
    output logic data_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = cnt_w(FILTER);

    logic [STAGES-1:0] sync_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              data_q, data_d;
    logic              rise_q, fall_q;
    logic              sync;
    logic              next_out;

    assign sync = sync_q[STAGES-1];

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (FILTER > 0 && sample_en_i) begin
            if (sync == data_q)
                cnt_d = '0;
            else if (cnt_q == CW'(FILTER - 1)) begin
                data_d = sync;
                cnt_d  = '0;
            end else
                cnt_d = cnt_q + 1'b1;
        end
    end

    // In bypass the last sync flop is the output, so its next value is the stage before it.
    assign next_out = (FILTER == 0) ? sync_q[STAGES-2] : data_d;
    assign data_o   = (FILTER == 0) ? sync : data_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            cnt_q  <= '0;
            data_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], data_i};
            cnt_q  <= cnt_d;
            data_q <= data_d;
            rise_q <= next_out & ~data_o;
            fall_q <= ~next_out & data_o;
        end
    end
endmodule

// File: rtl/peripheral_sync_filter.sv
// peripheral_sync_filter: WIDTH independent pad-input conditioners (sync, glitch filter, edge pulses)
// Ports:
//   clk    receiving clock
//   rst_n  asynchronous active-low reset
//   bus    slave modport: sample_en, data_in in; data_out, rise_out, fall_out out
module peripheral_sync_filter
    import peripheral_sync_pkg::*;
#(
    parameter int             WIDTH     = 1,
    parameter int             STAGES    = DEF_STAGES,
    parameter int             FILTER    = DEF_FILTER,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    peripheral_sync_filter_if.slave bus
);
    if (WIDTH < 1)  begin : g_bad_width  $error("WIDTH must be >= 1");  end
    if (STAGES < 2) begin : g_bad_stages $error("STAGES must be >= 2"); end
    if (FILTER < 0) begin : g_bad_filter $error("FILTER must be >= 0"); end
    if ($bits(bus.data_in) != WIDTH) begin : g_bad_if $error("interface WIDTH mismatch"); end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        peripheral_sync_filter_bit #(
            .STAGES   (STAGES),
            .FILTER   (FILTER),
            .RESET_VAL(RESET_VAL[i])
        ) u_bit (
            .clk        (clk),
            .rst_n      (rst_n),
            .sample_en_i(bus.sample_en),
            .data_i     (bus.data_in[i]),
            .data_o     (bus.data_out[i]),
            .rise_o     (bus.rise_out[i]),
            .fall_o     (bus.fall_out[i])
        );
    end
endmodule

// File: tb/tb_peripheral_sync_filter.sv
// tb_peripheral_sync_filter: directed checks of bypass, filter latency, glitch rejection, strobing and reset
module tb_peripheral_sync_filter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    peripheral_sync_filter_if #(.WIDTH(1)) b1 ();
    peripheral_sync_filter_if #(.WIDTH(4)) b2 ();
    peripheral_sync_filter_if #(.WIDTH(1)) b4 ();
    peripheral_sync_filter_if #(.WIDTH(1)) b5 ();

    peripheral_sync_filter #(.WIDTH(1), .STAGES(2), .FILTER(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    peripheral_sync_filter #(.WIDTH(4), .STAGES(3), .FILTER(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    peripheral_sync_filter #(.WIDTH(1), .STAGES(2), .FILTER(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    peripheral_sync_filter #(.WIDTH(1), .STAGES(2), .FILTER(3), .RESET_VAL(1'b1)) u5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] seen;
        b1.sample_en = 1'b1; b1.data_in = '0;
        b2.sample_en = 1'b1; b2.data_in = '0;
        b4.sample_en = 1'b1; b4.data_in = '0;
        b5.sample_en = 1'b1; b5.data_in = '0;
        do_reset();
        check("rst_out1", b1.data_out, 0);
        check("rst_out2", b2.data_out, 0);
        check("rst_out5", b5.data_out, 1);
        check("rst_edges2", {b2.rise_out, b2.fall_out}, 0);

        // bypass: two sync edges then the level appears with a one-cycle rise
        b1.data_in = 1'b1;
        tick(); check("t1_e1_out", b1.data_out, 0);
        tick(); check("t1_e2_out", b1.data_out, 1); check("t1_e2_rise", b1.rise_out, 1);
        tick(); check("t1_e3_out", b1.data_out, 1); check("t1_e3_rise", b1.rise_out, 0);

        // 4-bit STAGES=3 FILTER=4: 7-edge latency
        do_reset();
        b2.data_in = 4'hA;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("t2_out_%0d", t), b2.data_out, (t >= 7) ? 4'hA : 4'h0);
            check($sformatf("t2_rise_%0d", t), b2.rise_out, (t == 7) ? 4'hA : 4'h0);
            check($sformatf("t2_fall_%0d", t), b2.fall_out, 0);
        end

        // 3-cycle glitch is rejected
        do_reset();
        b2.data_in = 4'h0;
        tick(); tick(); tick(); tick(); tick(); tick();
        seen = '0;
        b2.data_in = 4'h1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 3) b2.data_in = 4'h0;
            seen = seen | b2.data_out | b2.rise_out | b2.fall_out;
        end
        check("t3_glitch3", seen, 0);

        // 4-cycle pulse passes: rise at edge 7, fall at edge 11
        b2.data_in = 4'h1;
        for (int t = 1; t <= 13; t++) begin
            tick();
            if (t == 4) b2.data_in = 4'h0;
            check($sformatf("t3_out_%0d", t), b2.data_out, (t >= 7 && t < 11) ? 4'h1 : 4'h0);
            check($sformatf("t3_rise_%0d", t), b2.rise_out, (t == 7) ? 4'h1 : 4'h0);
            check($sformatf("t3_fall_%0d", t), b2.fall_out, (t == 11) ? 4'h1 : 4'h0);
        end

        // FILTER=2 with a strobe every third cycle: change on the second strobed sample
        do_reset();
        b4.data_in = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            b4.sample_en = (t % 3 == 0);
            tick();
            check($sformatf("t4_out_%0d", t), b4.data_out, (t >= 6));
            check($sformatf("t4_rise_%0d", t), b4.rise_out, (t == 6));
        end
        b4.sample_en = 1'b1;

        // RESET_VAL=1 with pad low: no pulse at release, fall after 5 edges
        do_reset();
        check("t5_rel_out", b5.data_out, 1);
        check("t5_rel_edges", {b5.rise_out, b5.fall_out}, 0);
        for (int t = 1; t <= 7; t++) begin
            tick();
            check($sformatf("t5_out_%0d", t), b5.data_out, (t < 5));
            check($sformatf("t5_fall_%0d", t), b5.fall_out, (t == 5));
            check($sformatf("t5_rise_%0d", t), b5.rise_out, 0);
        end
        rst_n = 1'b0;
        #1;
        check("t5_async_out", b5.data_out, 1);
        check("t5_async_fall", b5.fall_out, 0);

        // reset while cnt == FILTER-1 discards the pending change
        do_reset();
        b2.data_in = 4'h1;
        for (int t = 1; t <= 6; t++) tick();
        check("t6_pre_out", b2.data_out, 0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", b2.data_out, 0);
        check("t6_rst_edges", {b2.rise_out, b2.fall_out}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("t6_out_%0d", t), b2.data_out, (t >= 7) ? 4'h1 : 4'h0);
            check($sformatf("t6_rise_%0d", t), b2.rise_out, (t == 7) ? 4'h1 : 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
